// File: rtl/cond_unit_e.sv
// cond_unit_e: Execute-stage condition unit.
// Holds the architectural NZCV flags, evaluates the instruction condition
// field against them, gates PC/register/memory write controls and registers
// the gated controls into the Memory stage.
//
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   StallE, FlushE      hold registers / squash the E-stage instruction
//   CondE[3:0]          condition field
//   FlagWriteE[1:0]     bit1 updates N,Z; bit0 updates C,V
//   ALUFlags[3:0]       {N,Z,C,V} from the Execute ALU
//   PCSrcE, RegWriteE, MemWriteE   raw E-stage write controls
//   Flags[3:0]          architectural {N,Z,C,V} (registered)
//   CondExE, PCSrcGE    condition result and gated PC write (combinational)
//   PCSrcM, RegWriteM, MemWriteM   gated controls, registered into M stage
module cond_unit_e (
    input  logic       clk,
    input  logic       reset,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic [3:0] CondE,
    input  logic [1:0] FlagWriteE,
    input  logic [3:0] ALUFlags,
    input  logic       PCSrcE,
    input  logic       RegWriteE,
    input  logic       MemWriteE,
    output logic [3:0] Flags,
    output logic       CondExE,
    output logic       PCSrcGE,
    output logic       PCSrcM,
    output logic       RegWriteM,
    output logic       MemWriteM
);

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned COND_W = 4;

    typedef enum logic [COND_W-1:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    logic [FLAG_W-1:0] r_flags;
    logic              r_pcsrc_m;
    logic              r_regwrite_m;
    logic              r_memwrite_m;

    logic              w_n;
    logic              w_z;
    logic              w_c;
    logic              w_v;
    logic              w_ge;
    logic              w_cond_pass;
    logic              w_gate;
    logic              w_flag_we;
    cond_e             w_cond;

    assign w_n    = r_flags[3];
    assign w_z    = r_flags[2];
    assign w_c    = r_flags[1];
    assign w_v    = r_flags[0];
    assign w_ge   = (w_n == w_v);
    assign w_cond = cond_e'(CondE);

    // Condition check against the registered flags only (no ALU forwarding).
    always_comb begin
        w_cond_pass = 1'b0;
        case (w_cond)
            COND_EQ: w_cond_pass = w_z;
            COND_NE: w_cond_pass = ~w_z;
            COND_CS: w_cond_pass = w_c;
            COND_CC: w_cond_pass = ~w_c;
            COND_MI: w_cond_pass = w_n;
            COND_PL: w_cond_pass = ~w_n;
            COND_VS: w_cond_pass = w_v;
            COND_VC: w_cond_pass = ~w_v;
            COND_HI: w_cond_pass = w_c & ~w_z;
            COND_LS: w_cond_pass = ~(w_c & ~w_z);
            COND_GE: w_cond_pass = w_ge;
            COND_LT: w_cond_pass = ~w_ge;
            COND_GT: w_cond_pass = ~w_z & w_ge;
            COND_LE: w_cond_pass = ~(~w_z & w_ge);
            COND_AL: w_cond_pass = 1'b1;
            COND_NV: w_cond_pass = 1'b0;
            default: w_cond_pass = 1'b0;
        endcase
    end

    // A squashed or failed instruction has no side effects; stall blocks writes.
    assign w_gate    = w_cond_pass & ~FlushE;
    assign w_flag_we = w_gate & ~StallE;

    // Flag register; NZ and CV halves update independently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
        end else if (w_flag_we) begin
            if (FlagWriteE[1]) r_flags[3:2] <= ALUFlags[3:2];
            if (FlagWriteE[0]) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    // E/M control pipeline register; holds while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcsrc_m    <= 1'b0;
            r_regwrite_m <= 1'b0;
            r_memwrite_m <= 1'b0;
        end else if (!StallE) begin
            r_pcsrc_m    <= PCSrcE    & w_gate;
            r_regwrite_m <= RegWriteE & w_gate;
            r_memwrite_m <= MemWriteE & w_gate;
        end
    end

    assign Flags     = r_flags;
    assign CondExE   = w_cond_pass;
    assign PCSrcGE   = PCSrcE & w_gate;
    assign PCSrcM    = r_pcsrc_m;
    assign RegWriteM = r_regwrite_m;
    assign MemWriteM = r_memwrite_m;

endmodule

// File: tb/tb_cond_unit_e.sv
module tb_cond_unit_e;

    logic       clk;
    logic       reset;
    logic       StallE;
    logic       FlushE;
    logic [3:0] CondE;
    logic [1:0] FlagWriteE;
    logic [3:0] ALUFlags;
    logic       PCSrcE;
    logic       RegWriteE;
    logic       MemWriteE;
    logic [3:0] Flags;
    logic       CondExE;
    logic       PCSrcGE;
    logic       PCSrcM;
    logic       RegWriteM;
    logic       MemWriteM;

    cond_unit_e dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .Flags(Flags), .CondExE(CondExE), .PCSrcGE(PCSrcGE),
        .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] flags;
        logic       pc;
        logic       rw;
        logic       mw;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference architectural state
    logic [3:0] m_flags;
    logic       m_pc, m_rw, m_mw;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ARM condition semantics written in terms of unsigned/signed comparisons.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, eq, uns_ge, sgn_ge;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        eq     = z;
        uns_ge = cf;
        sgn_ge = (n == v);
        case (c)
            4'd0:  return eq;
            4'd1:  return !eq;
            4'd2:  return uns_ge;
            4'd3:  return !uns_ge;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return uns_ge && !eq;
            4'd9:  return !(uns_ge && !eq);
            4'd10: return sgn_ge;
            4'd11: return !sgn_ge;
            4'd12: return sgn_ge && !eq;
            4'd13: return !(sgn_ge && !eq);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Apply one E-stage instruction, check combinational outputs, push expectation.
    task automatic drive(input bit st, input bit fl, input logic [3:0] c,
                         input logic [1:0] fw, input logic [3:0] alu,
                         input bit pc, input bit rw, input bit mw);
        bit   pass, go;
        exp_t e;
        @(negedge clk);
        StallE = st; FlushE = fl; CondE = c; FlagWriteE = fw; ALUFlags = alu;
        PCSrcE = pc; RegWriteE = rw; MemWriteE = mw;
        #1;
        pass = cond_ok(c, m_flags);
        go   = pass && !fl;
        chk("CondExE", 8'(CondExE), 8'(pass));
        chk("PCSrcGE", 8'(PCSrcGE), 8'(pc && go));
        if (!st) begin
            if (go && fw[1]) m_flags[3:2] = alu[3:2];
            if (go && fw[0]) m_flags[1:0] = alu[1:0];
            m_pc = pc && go;
            m_rw = rw && go;
            m_mw = mw && go;
        end
        e.flags = m_flags; e.pc = m_pc; e.rw = m_rw; e.mw = m_mw;
        q.push_back(e);
    endtask

    // Monitor: after every rising edge, compare registered state to the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("Flags",     8'(Flags),     8'(e.flags));
                chk("PCSrcM",    8'(PCSrcM),    8'(e.pc));
                chk("RegWriteM", 8'(RegWriteM), 8'(e.rw));
                chk("MemWriteM", 8'(MemWriteM), 8'(e.mw));
            end
        end
    end

    initial begin
        reset = 1'b1; StallE = 0; FlushE = 0; CondE = 4'b0001; FlagWriteE = 0;
        ALUFlags = 0; PCSrcE = 0; RegWriteE = 0; MemWriteE = 0;
        m_flags = 0; m_pc = 0; m_rw = 0; m_mw = 0;
        #3;
        chk("reset_flags", 8'(Flags), 8'h0);
        chk("reset_regwm", 8'(RegWriteM), 8'h0);
        chk("reset_ne_pass", 8'(CondExE), 8'h1);
        reset = 1'b0;

        // Reset with flags=1111 and RegWriteM=1 clears immediately
        drive(0, 0, 4'b1110, 2'b11, 4'b1111, 0, 1, 0);
        @(posedge clk);
        #3;
        chk("pre_reset_flags", 8'(Flags), 8'hF);
        reset = 1'b1;
        #1;
        chk("async_reset_flags", 8'(Flags), 8'h0);
        chk("async_reset_regwm", 8'(RegWriteM), 8'h0);
        reset = 1'b0;
        m_flags = 0; m_pc = 0; m_rw = 0; m_mw = 0;

        // Flag write then use by the next instruction
        drive(0, 0, 4'b1110, 2'b11, 4'b0100, 0, 0, 0);
        drive(0, 0, 4'b0000, 2'b00, 4'b0000, 0, 1, 0);

        // Partial write: 1010 with NZ update from 0101 -> 0110
        drive(0, 0, 4'b1110, 2'b11, 4'b1010, 0, 0, 0);
        drive(0, 0, 4'b1110, 2'b10, 4'b0101, 0, 0, 0);

        // Failed condition suppresses everything
        drive(0, 0, 4'b1110, 2'b11, 4'b0000, 0, 0, 0);
        drive(0, 0, 4'b0000, 2'b11, 4'b1111, 1, 0, 1);

        // Spot checks: GT with 1001, LT with 1000
        drive(0, 0, 4'b1110, 2'b11, 4'b1001, 0, 0, 0);
        drive(0, 0, 4'b1100, 2'b00, 4'b0000, 1, 1, 1);
        drive(0, 0, 4'b1110, 2'b11, 4'b1000, 0, 0, 0);
        drive(0, 0, 4'b1011, 2'b00, 4'b0000, 1, 1, 1);

        // Full condition table sweep
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                drive(0, 0, 4'b1110, 2'b11, 4'(f), 0, 0, 0);
                drive(0, 0, 4'(c), 2'b00, 4'b0000, 1, 1, 1);
            end
        end

        // Stall, flush, and both together
        drive(0, 0, 4'b1110, 2'b11, 4'b0110, 1, 1, 1);
        drive(1, 0, 4'b1110, 2'b11, 4'b1001, 0, 0, 0);
        drive(0, 1, 4'b1110, 2'b00, 4'b0000, 1, 0, 0);
        drive(0, 0, 4'b1110, 2'b00, 4'b0000, 1, 1, 1);
        drive(1, 1, 4'b1110, 2'b11, 4'b0000, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  4'($urandom), 2'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        StallE = 1; FlushE = 0; FlagWriteE = 0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_unit_e.md
# cond_unit_e

Execute-stage condition unit for the pipelined ARM core. Holds the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against it. Gates the instruction's PC-write, register-write and memory-write controls and forwards the gated controls to the Memory stage through an internal pipeline register. Sits between the Decode/Execute control register (upstream) and the Execute/Memory control path (downstream). Receives ALU flags from the Execute-stage ALU.

## Interface
- No parameters; all widths fixed by the ARM encoding.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- StallE  in  1  when high, flag register and M-stage register hold.
- FlushE  in  1  when high, current E instruction is squashed: no flag write, all gated controls 0.
- CondE  in  4  instruction condition field, bits [31:28].
- FlagWriteE  in  2  bit1 = update N,Z; bit0 = update C,V.
- ALUFlags  in  4  {N,Z,C,V} from the Execute ALU, same cycle.
- PCSrcE  in  1  instruction writes PC (branch or PC destination).
- RegWriteE  in  1  instruction writes register file.
- MemWriteE  in  1  instruction writes memory.
- Flags  out  4  current architectural {N,Z,C,V}.
- CondExE  out  1  condition passed for the E-stage instruction (combinational).
- PCSrcGE  out  1  PCSrcE & CondExE & ~FlushE (combinational, to fetch redirect).
- PCSrcM  out  1  registered gated PCSrc.
- RegWriteM  out  1  registered gated RegWrite.
- MemWriteM  out  1  registered gated MemWrite.

## Operation
- Condition evaluation uses Flags (register output, never ALUFlags):
  - 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V.
  - 1000 C&~Z; 1001 ~(C&~Z); 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 ~(~Z&(N==V)); 1110 1.
  - 1111 0 (defined value; never X).
- Flag write enables, valid only when CondExE & ~FlushE & ~StallE:
  - FlagWriteE[1]: Flags[3:2] <= ALUFlags[3:2].
  - FlagWriteE[0]: Flags[1:0] <= ALUFlags[1:0].
  - The two halves update independently.
- Gated control = raw control & CondExE & ~FlushE.
- M-stage register:
  - ~StallE: PCSrcM/RegWriteM/MemWriteM <= gated PCSrc/RegWrite/MemWrite.
  - StallE: hold.
- A failed condition suppresses every side effect: no flag update, PCSrcGE=0, M-stage controls 0.
- No state machine beyond the flag register and the M-stage register.

## Timing
- Reset (asynchronous, immediate): Flags=0000, PCSrcM=RegWriteM=MemWriteM=0.
  - Combinational outputs follow from the reset Flags value, e.g. CondE=0001 gives CondExE=1.
- CondExE and PCSrcGE are zero-latency from CondE, FlushE and Flags.
- Flags update at the rising edge that ends the instruction's E cycle.
  - The next instruction (next E cycle) sees the new flags.
  - No forwarding path from ALUFlags is needed or permitted.
- M-stage outputs have 1-cycle latency.
- Simultaneous FlushE and StallE: StallE wins for the registers (hold). Combinational outputs are still squashed by FlushE.
- Reset asserted mid-stream: pending M-stage controls are discarded; flags clear on the same edge/instant.
- Deassertion of reset is treated as synchronous-safe; the first rising edge after deassertion updates normally.

## Test plan
- Reset: assert reset with Flags previously 1111 and RegWriteM=1 -> Flags=0000 and RegWriteM=0 immediately, with no clock edge.
- Flag write and use: cycle 0: CondE=1110, FlagWriteE=11, ALUFlags=0100 -> after edge Flags=0100. Cycle 1: CondE=0000, RegWriteE=1 -> CondExE=1; RegWriteM=1 after the edge.
- Partial write: Flags=1010, FlagWriteE=10, ALUFlags=0101 -> Flags=0110 (NZ updated, CV kept).
- Failed condition: Flags=0000, CondE=0000, FlagWriteE=11, ALUFlags=1111, MemWriteE=1, PCSrcE=1 -> CondExE=0, PCSrcGE=0; after the edge Flags=0000 and MemWriteM=0.
- Signed compares: sweep all 16 Flags values x all 16 CondE values -> CondExE matches the table; CondE=1111 always gives 0. Spot checks: Flags=1001 with GT gives 1; Flags=1000 with LT gives 1.
- Stall/flush: StallE=1 with FlagWriteE=11 -> Flags and M-stage registers hold. FlushE=1 with CondE=1110, PCSrcE=1 -> PCSrcGE=0 and PCSrcM=0 next cycle. StallE=1 and FlushE=1 together -> registers hold.
